// File: rtl/branch_predictor_dyn_if.sv
// Lookup/update port bundle between the ID/EX pipeline
// stages and the dynamic branch predictor.
interface branch_predictor_dyn_if #(
  parameter int PC_WIDTH   = 32,
  parameter int IDX_BITS   = 4,
  parameter int STAT_WIDTH = 32
);
  logic [PC_WIDTH-1:0]   i_lookup_pc;
  logic                  o_predict_taken;
  logic [IDX_BITS-1:0]   o_lookup_idx;
  logic                  i_update_valid;
  logic [IDX_BITS-1:0]   i_update_idx;
  logic                  i_update_taken;
  logic                  i_update_mispredicted;
  logic [IDX_BITS-1:0]   o_ghr;
  logic [STAT_WIDTH-1:0] o_branch_count;
  logic [STAT_WIDTH-1:0] o_mispredict_count;

  modport master (
    output i_lookup_pc,
    output i_update_valid,
    output i_update_idx,
    output i_update_taken,
    output i_update_mispredicted,
    input  o_predict_taken,
    input  o_lookup_idx,
    input  o_ghr,
    input  o_branch_count,
    input  o_mispredict_count
  );

  modport slave (
    input  i_lookup_pc,
    input  i_update_valid,
    input  i_update_idx,
    input  i_update_taken,
    input  i_update_mispredicted,
    output o_predict_taken,
    output o_lookup_idx,
    output o_ghr,
    output o_branch_count,
    output o_mispredict_count
  );
endinterface

// File: rtl/branch_predictor_dyn.sv
// Bimodal/gshare predictor: combinational ID lookup,
// EX-resolved training of saturating counters plus stats.
module branch_predictor_dyn #(
  parameter int ENTRIES    = 16,
  parameter int CTR_BITS   = 2,
  parameter int MODE       = 0,
  parameter int PC_WIDTH   = 32,
  parameter int STAT_WIDTH = 32
) (
  input logic clk,
  input logic reset,
  branch_predictor_dyn_if.slave bp
);
  localparam int IDX_BITS = $clog2(ENTRIES);

  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_MAX >> 1;
  localparam logic [STAT_WIDTH-1:0] STAT_MAX = '1;

  logic [CTR_BITS-1:0]   ctr [ENTRIES];
  logic [IDX_BITS-1:0]   ghr;
  logic [IDX_BITS-1:0]   ghr_nxt;
  logic [IDX_BITS-1:0]   pc_idx;
  logic [IDX_BITS-1:0]   look_idx;
  logic [CTR_BITS-1:0]   upd_cur;
  logic [CTR_BITS-1:0]   upd_nxt;
  logic [STAT_WIDTH-1:0] br_cnt;
  logic [STAT_WIDTH-1:0] mp_cnt;

  assign pc_idx = bp.i_lookup_pc[IDX_BITS+1:2];

  logic unused_pc;
  if (PC_WIDTH > IDX_BITS + 2) begin : g_pc_hi
    assign unused_pc = ^{bp.i_lookup_pc[PC_WIDTH-1:IDX_BITS+2],
                         bp.i_lookup_pc[1:0]};
  end else begin : g_pc_lo
    assign unused_pc = ^bp.i_lookup_pc[1:0];
  end

  if (MODE == 1) begin : g_gshare
    assign look_idx = pc_idx ^ ghr;
  end else begin : g_bimodal
    assign look_idx = pc_idx;
  end

  if (IDX_BITS == 1) begin : g_ghr1
    assign ghr_nxt = bp.i_update_taken;
  end else begin : g_ghrn
    assign ghr_nxt = {ghr[IDX_BITS-2:0], bp.i_update_taken};
  end

  assign upd_cur = ctr[bp.i_update_idx];

  always_comb begin
    upd_nxt = upd_cur;
    unique case (1'b1)
      bp.i_update_taken && (upd_cur != CTR_MAX):
        upd_nxt = upd_cur + 1'b1;
      !bp.i_update_taken && (upd_cur != '0):
        upd_nxt = upd_cur - 1'b1;
      default:
        upd_nxt = upd_cur;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr[i] <= CTR_INIT;
      end
      ghr    <= '0;
      br_cnt <= '0;
      mp_cnt <= '0;
    end else if (bp.i_update_valid) begin
      ctr[bp.i_update_idx] <= upd_nxt;
      ghr <= ghr_nxt;
      if (br_cnt != STAT_MAX) begin
        br_cnt <= br_cnt + 1'b1;
      end
      if (bp.i_update_mispredicted && (mp_cnt != STAT_MAX)) begin
        mp_cnt <= mp_cnt + 1'b1;
      end
    end
  end

  // Read uses the pre-edge table: no write-to-read bypass.
  assign bp.o_predict_taken    = ctr[look_idx][CTR_BITS-1];
  assign bp.o_lookup_idx       = look_idx;
  assign bp.o_ghr              = ghr;
  assign bp.o_branch_count     = br_cnt;
  assign bp.o_mispredict_count = mp_cnt;
endmodule

// File: tb/tb_branch_predictor_dyn.sv
// Scoreboard bench: bimodal (4-bit stats) and gshare
// instances driven in lockstep against a reference model.
module tb_branch_predictor_dyn;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  branch_predictor_dyn_if #(
    .PC_WIDTH(32), .IDX_BITS(4), .STAT_WIDTH(4)
  ) if_a ();
  branch_predictor_dyn_if #(
    .PC_WIDTH(32), .IDX_BITS(4), .STAT_WIDTH(32)
  ) if_b ();

  branch_predictor_dyn #(
    .ENTRIES(16), .CTR_BITS(2), .MODE(0),
    .PC_WIDTH(32), .STAT_WIDTH(4)
  ) dut_a (
    .clk(clk), .reset(reset), .bp(if_a)
  );

  branch_predictor_dyn #(
    .ENTRIES(16), .CTR_BITS(2), .MODE(1),
    .PC_WIDTH(32), .STAT_WIDTH(32)
  ) dut_b (
    .clk(clk), .reset(reset), .bp(if_b)
  );

  typedef struct {
    bit     pt;
    int     idx;
    int     ghr;
    longint bc;
    longint mc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea;
  exp_t eb;

  int checks = 0;
  int failures = 0;

  int     ctr [2][16];
  int     ghr [2];
  longint bc [2];
  longint mc [2];
  longint smax [2];
  int     mode [2];
  bit     known = 1'b0;

  function automatic void chk(string n, longint a, longint e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endfunction

  function automatic exp_t predict(int d, bit [31:0] pc);
    exp_t e;
    int pi;
    int idx;
    pi = int'((pc / 4) % 16);
    idx = (mode[d] == 1) ? (pi ^ ghr[d]) : pi;
    e.pt = (ctr[d][idx] >= 2);
    e.idx = idx;
    e.ghr = ghr[d];
    e.bc = bc[d];
    e.mc = mc[d];
    return e;
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) ctr[d][i] = 1;
      ghr[d] = 0;
      bc[d] = 0;
      mc[d] = 0;
    end
  endfunction

  function automatic void model_update(int idx, bit t, bit m);
    for (int d = 0; d < 2; d++) begin
      if (t) ctr[d][idx] = (ctr[d][idx] < 3) ? ctr[d][idx] + 1 : 3;
      else   ctr[d][idx] = (ctr[d][idx] > 0) ? ctr[d][idx] - 1 : 0;
      ghr[d] = (ghr[d] * 2 + int'(t)) % 16;
      if (bc[d] < smax[d]) bc[d] = bc[d] + 1;
      if (m && mc[d] < smax[d]) mc[d] = mc[d] + 1;
    end
  endfunction

  task automatic step(bit r, bit [31:0] pc, bit uv, int uidx,
                      bit ut, bit um);
    @(posedge clk);
    #1;
    reset = r;
    if_a.i_lookup_pc = pc;
    if_b.i_lookup_pc = pc;
    if_a.i_update_valid = uv;
    if_b.i_update_valid = uv;
    if_a.i_update_idx = 4'(uidx);
    if_b.i_update_idx = 4'(uidx);
    if_a.i_update_taken = ut;
    if_b.i_update_taken = ut;
    if_a.i_update_mispredicted = um;
    if_b.i_update_mispredicted = um;
    if (known) begin
      qa.push_back(predict(0, pc));
      qb.push_back(predict(1, pc));
    end
    if (r) begin
      model_reset();
      known = 1'b1;
    end else if (uv && known) begin
      model_update(uidx, ut, um);
    end
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (qa.size() > 0) begin
      ea = qa.pop_front();
      chk("a_pred", longint'(if_a.o_predict_taken), longint'(ea.pt));
      chk("a_idx", longint'(if_a.o_lookup_idx), longint'(ea.idx));
      chk("a_ghr", longint'(if_a.o_ghr), longint'(ea.ghr));
      chk("a_bcnt", longint'(if_a.o_branch_count), ea.bc);
      chk("a_mcnt", longint'(if_a.o_mispredict_count), ea.mc);
    end
    if (qb.size() > 0) begin
      eb = qb.pop_front();
      chk("b_pred", longint'(if_b.o_predict_taken), longint'(eb.pt));
      chk("b_idx", longint'(if_b.o_lookup_idx), longint'(eb.idx));
      chk("b_ghr", longint'(if_b.o_ghr), longint'(eb.ghr));
      chk("b_bcnt", longint'(if_b.o_branch_count), eb.bc);
      chk("b_mcnt", longint'(if_b.o_mispredict_count), eb.mc);
    end
  end

  initial begin
    int sat_pt [6];
    bit sat_t [5];
    mode[0] = 0;
    mode[1] = 1;
    smax[0] = 15;
    smax[1] = longint'(32'hFFFF_FFFF);
    sat_pt = '{0, 1, 1, 1, 1, 0};
    sat_t = '{1, 1, 1, 0, 0};
    if_a.i_lookup_pc = '0;
    if_b.i_lookup_pc = '0;
    if_a.i_update_valid = 1'b0;
    if_b.i_update_valid = 1'b0;
    if_a.i_update_idx = '0;
    if_b.i_update_idx = '0;
    if_a.i_update_taken = 1'b0;
    if_b.i_update_taken = 1'b0;
    if_a.i_update_mispredicted = 1'b0;
    if_b.i_update_mispredicted = 1'b0;

    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 32'h00, 0, 0, 0, 0);
    chk("rst_pred_00", longint'(if_a.o_predict_taken), 0);
    chk("rst_idx_00", longint'(if_a.o_lookup_idx), 0);
    chk("rst_bcnt", longint'(if_a.o_branch_count), 0);
    chk("rst_ghr", longint'(if_a.o_ghr), 0);
    step(0, 32'h3C, 0, 0, 0, 0);
    chk("rst_pred_3c", longint'(if_a.o_predict_taken), 0);
    chk("rst_idx_3c", longint'(if_a.o_lookup_idx), 15);
    step(0, 32'h40, 0, 0, 0, 0);
    chk("rst_idx_40", longint'(if_a.o_lookup_idx), 0);

    for (int i = 0; i < 5; i++) begin
      step(0, 32'h0C, 1, 3, sat_t[i], 0);
      chk("sat_pred", longint'(if_a.o_predict_taken),
          longint'(sat_pt[i]));
    end
    step(0, 32'h0C, 0, 0, 0, 0);
    chk("sat_pred_end", longint'(if_a.o_predict_taken),
        longint'(sat_pt[5]));

    step(0, 32'h14, 1, 5, 1, 0);
    chk("byp_same_cycle", longint'(if_a.o_predict_taken), 0);
    step(0, 32'h14, 0, 0, 0, 0);
    chk("byp_next_cycle", longint'(if_a.o_predict_taken), 1);

    step(1, 0, 0, 0, 0, 0);
    step(0, 32'h40, 1, 0, 1, 0);
    step(0, 32'h40, 1, 0, 1, 0);
    step(0, 32'h40, 1, 0, 0, 0);
    step(0, 32'h40, 0, 0, 0, 0);
    chk("gshare_ghr", longint'(if_b.o_ghr), 6);
    chk("gshare_idx", longint'(if_b.o_lookup_idx), 6);
    chk("bimodal_ghr", longint'(if_a.o_ghr), 6);

    for (int i = 0; i < 17; i++) begin
      step(0, $urandom, 1, int'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), 1);
    end
    step(0, 32'h0, 0, 0, 1, 1);
    chk("stat_bcnt_sat", longint'(if_a.o_branch_count), 15);
    chk("stat_mcnt_sat", longint'(if_a.o_mispredict_count), 15);
    step(0, 32'h0, 0, 0, 0, 0);
    chk("stat_bcnt_hold", longint'(if_a.o_branch_count), 15);

    step(1, 0, 0, 0, 0, 0);
    step(0, 32'h08, 1, 2, 1, 1);
    step(0, 32'h08, 1, 2, 1, 1);
    step(1, 32'h08, 1, 2, 1, 1);
    step(0, 32'h08, 0, 0, 0, 0);
    chk("mid_rst_pred", longint'(if_a.o_predict_taken), 0);
    chk("mid_rst_bcnt", longint'(if_a.o_branch_count), 0);
    chk("mid_rst_mcnt", longint'(if_a.o_mispredict_count), 0);
    chk("mid_rst_ghr", longint'(if_a.o_ghr), 0);
    step(0, 32'h08, 1, 2, 1, 0);
    chk("mid_rst_pre", longint'(if_a.o_predict_taken), 0);
    step(0, 32'h08, 0, 0, 0, 0);
    chk("mid_rst_ctr1", longint'(if_a.o_predict_taken), 1);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 59) == 0, $urandom,
           1'($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
    end
    step(0, 32'h0, 0, 0, 0, 0);

    chk("queue_drained", longint'(qa.size() + qb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/branch_predictor_dyn.md
Name: branch_predictor_dyn

Overview:
- Parametrised dynamic branch predictor that replaces the pipeline's static not-taken prediction.
- ID stage performs a combinational lookup and gets a taken/not-taken prediction plus the table index. The index is carried down the ID/EX latch.
- EX stage returns the resolved outcome with that index to train a table of saturating counters.
- Supports bimodal (PC-indexed) or gshare (PC XOR global history) mode and keeps saturating branch/mispredict statistics.

Parameters:
- ENTRIES, 16, number of counter entries; power of two, >= 2; IDX_BITS = log2(ENTRIES).
- CTR_BITS, 2, width of each saturating counter, >= 1.
- MODE, 0, 0 = bimodal, 1 = gshare.
- PC_WIDTH, 32, width of the PC inputs.
- STAT_WIDTH, 32, width of each statistics counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- i_lookup_pc  input  PC_WIDTH  PC of the instruction in ID.
- o_predict_taken  output  1  combinational prediction for i_lookup_pc.
- o_lookup_idx  output  IDX_BITS  index used for this lookup; the pipeline carries it to EX.
- i_update_valid  input  1  a branch resolved in EX this cycle.
- i_update_idx  input  IDX_BITS  index returned from the ID/EX latch.
- i_update_taken  input  1  actual branch outcome.
- i_update_mispredicted  input  1  EX detected a misprediction.
- o_ghr  output  IDX_BITS  current global history register (debug).
- o_branch_count  output  STAT_WIDTH  resolved branches since reset.
- o_mispredict_count  output  STAT_WIDTH  mispredictions since reset.

Behaviour:
- Reset (synchronous, active-high):
  - All counters go to weakly-not-taken, 2^(CTR_BITS-1)-1.
  - GHR = 0; both statistics counters = 0.
  - o_predict_taken therefore reads 0 for every PC the cycle after reset.
  - Reset has priority over a same-cycle update; a mid-operation reset discards all training.
- Index:
  - pc_idx = i_lookup_pc[IDX_BITS+1:2].
  - MODE 0: o_lookup_idx = pc_idx.
  - MODE 1: o_lookup_idx = pc_idx XOR GHR.
- Lookup:
  - Purely combinational; zero latency.
  - o_predict_taken = MSB of counter[o_lookup_idx].
- Update (when i_update_valid=1, at the clock edge):
  - counter[i_update_idx] increments if i_update_taken=1, decrements otherwise.
  - Counters saturate at 2^CTR_BITS-1 and 0; no wrap.
  - GHR <= {GHR[IDX_BITS-2:0], i_update_taken}. For IDX_BITS=1, GHR <= i_update_taken.
  - The GHR is updated in both modes, but only MODE 1 uses it for indexing.
  - o_branch_count += 1, saturating at all-ones.
  - o_mispredict_count += 1 if i_update_mispredicted=1, saturating at all-ones.
- No update when i_update_valid=0:
  - i_update_taken and i_update_mispredicted are ignored; no state changes.
- Simultaneous lookup and update to the same index:
  - The lookup returns the pre-update counter value; there is no write-to-read bypass.
  - In MODE 1 the lookup index uses the pre-update GHR.
  - The new value is visible the following cycle.
- Stalls and flushes are handled outside the block:
  - A flushed branch never reaches EX, so it never asserts i_update_valid.
  - The predictor holds no speculative state; the GHR is trained only on resolved outcomes.
- One update per cycle at most.
- All outputs except o_predict_taken and o_lookup_idx are registered state.

Test Plan:
- Reset then lookup:
  - Stimulus: assert reset 2 cycles, release; look up PCs 0x00, 0x3C, 0x40.
  - Required: o_predict_taken=0 for all; o_lookup_idx = 0, 15, 0; counts = 0; o_ghr = 0.
- Counter saturation (MODE 0, CTR_BITS=2, index 3, PC 0x0C):
  - Stimulus: updates T, T, T, N, N.
  - Required: counter goes 1 -> 2 -> 3 -> 3 -> 2 -> 1; o_predict_taken after each update = 1, 1, 1, 1, 0.
- Same-cycle lookup and update at index 5 (counter=1):
  - Stimulus: lookup PC 0x14 while updating index 5 taken.
  - Required: o_predict_taken=0 that cycle, 1 the next cycle.
- gshare (MODE 1):
  - Stimulus: updates T, T, N to index 0.
  - Required: o_ghr = 4'b0110; lookup of PC 0x40 gives o_lookup_idx = 6.
- Statistics (STAT_WIDTH=4):
  - Stimulus: 17 updates, each with i_update_mispredicted=1.
  - Required: o_branch_count = 15, o_mispredict_count = 15, both held at 15.
  - Also: a cycle with i_update_valid=0 and i_update_mispredicted=1 changes nothing.
- Reset mid-operation:
  - Stimulus: train index 2 to 3, then assert reset in the same cycle as a taken update to index 2.
  - Required: next cycle counter[2] = 1, o_predict_taken for PC 0x08 = 0, counts = 0, o_ghr = 0.
